// File: rtl/ccu_pkg.sv
// ---------------------------------------------------------------------------
// ccu_pkg
// Shared definitions for the coincidence counting window controller:
//   - ccu_state_e : FSM state encoding (IDLE, ARM, COUNT, DONE)
//   - CCU_CNT_W   : default width of every count output
//   - CCU_WIN_W   : default width of the window length
//   - CCU_TOL_W   : default width of the coincidence tolerance
//   - CCU_ACC_DLY : default delay (cycles) applied to pulse_b for the
//                   accidental-coincidence estimate
// ---------------------------------------------------------------------------
package ccu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_COUNT = 2'd2,
      ST_DONE  = 2'd3
   } ccu_state_e;

   localparam int CCU_CNT_W   = 32;
   localparam int CCU_WIN_W   = 32;
   localparam int CCU_TOL_W   = 3;
   localparam int CCU_ACC_DLY = 16;

endpackage

// File: rtl/coinc_match.sv
// ---------------------------------------------------------------------------
// coinc_match
// Tolerance/pairing matcher between two single-cycle pulse channels.
// A coincidence is flagged when a pulse arrives on one channel while the other
// channel holds an unpaired pulse aged 0..tol cycles (age 0 = same cycle).
// Each pulse takes part in at most one coincidence; simultaneous pulses on
// both channels form exactly one coincidence with each other.
//
// Ports:
//   clk      in   clock (posedge)
//   rst_n    in   synchronous active-low reset
//   clear    in   drop any held pulses (start of a window)
//   en       in   pulses are only considered while en=1
//   pulse_x  in   channel X pulse
//   pulse_y  in   channel Y pulse
//   tol      in   tolerance in cycles
//   match    out  combinational: one coincidence this cycle
// ---------------------------------------------------------------------------
module coinc_match
   import ccu_pkg::*;
#(
   parameter int TOL_W = CCU_TOL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic             pulse_x,
   input  logic             pulse_y,
   input  logic [TOL_W-1:0] tol,
   output logic             match
);

   // One tracker per channel holds the most recent unpaired pulse. A newer
   // unpaired pulse on the same channel replaces the older one, since the
   // newer pulse always stays inside the tolerance window longer.
   // The stored age is the age the pulse has during the current cycle, so a
   // pulse stored this cycle reads age 1 next cycle.
   logic             held_x;
   logic             held_y;
   logic [TOL_W-1:0] age_x;
   logic [TOL_W-1:0] age_y;

   logic             held_x_nxt;
   logic             held_y_nxt;
   logic [TOL_W-1:0] age_x_nxt;
   logic [TOL_W-1:0] age_y_nxt;
   logic             live_x;
   logic             live_y;

   always_comb begin
      live_x     = held_x && (age_x <= tol);
      live_y     = held_y && (age_y <= tol);
      match      = 1'b0;
      held_x_nxt = held_x;
      held_y_nxt = held_y;
      age_x_nxt  = age_x;
      age_y_nxt  = age_y;

      if (en) begin
         // Age held pulses; a pulse that reaches tol this cycle expires
         // after it, which also keeps the age from exceeding tol.
         held_x_nxt = held_x && (age_x < tol);
         held_y_nxt = held_y && (age_y < tol);
         if (age_x < tol) begin
            age_x_nxt = age_x + 1'b1;
         end
         if (age_y < tol) begin
            age_y_nxt = age_y + 1'b1;
         end

         if (pulse_x && pulse_y) begin
            // Both new pulses pair with each other; older held pulses
            // keep aging untouched.
            match = 1'b1;
         end else if (pulse_x) begin
            if (live_y) begin
               match      = 1'b1;
               held_y_nxt = 1'b0;
            end else begin
               held_x_nxt = 1'b1;
               age_x_nxt  = TOL_W'(1);
            end
         end else if (pulse_y) begin
            if (live_x) begin
               match      = 1'b1;
               held_x_nxt = 1'b0;
            end else begin
               held_y_nxt = 1'b1;
               age_y_nxt  = TOL_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         held_x <= 1'b0;
         held_y <= 1'b0;
         age_x  <= '0;
         age_y  <= '0;
      end else begin
         held_x <= held_x_nxt;
         held_y <= held_y_nxt;
         age_x  <= age_x_nxt;
         age_y  <= age_y_nxt;
      end
   end

endmodule

// File: rtl/count_window_ctrl.sv
// ---------------------------------------------------------------------------
// count_window_ctrl
// Counts singles on two detector channels and their coincidences over a
// programmable window, then presents the counts with a valid/ack handshake.
//
// Handshake: valid rises one cycle after the last COUNT cycle together with
// new count values; it stays high (counts stable) until ack is sampled high,
// and the next cycle valid is low again. ack has no effect when valid is low.
//
// Optional feature (macro CCU_ACCIDENTALS_EN): adds count_acc, coincidences of
// pulse_a against pulse_b delayed by ACC_DLY cycles (accidental estimate).
//
// Ports:
//   clk         in   clock (posedge)
//   rst_n       in   synchronous active-low reset
//   pulse_a     in   channel A detector pulse
//   pulse_b     in   channel B detector pulse
//   start       in   open a window (IDLE only)
//   abort       in   cancel a window in ARM/COUNT
//   window_len  in   window length in cycles (0 behaves as 1)
//   tol         in   coincidence tolerance in cycles
//   ack         in   consumer has taken the results
//   busy        out  high in every state except IDLE
//   valid       out  counts are stable and unread
//   count_a     out  singles A of the last completed window
//   count_b     out  singles B of the last completed window
//   count_ab    out  AB coincidences of the last completed window
//   state_dbg   out  current FSM state (ccu_state_e encoding)
//   count_acc   out  accidental coincidences (CCU_ACCIDENTALS_EN only)
// ---------------------------------------------------------------------------
module count_window_ctrl
   import ccu_pkg::*;
#(
   parameter int CNT_W = CCU_CNT_W,
   parameter int WIN_W = CCU_WIN_W,
   parameter int TOL_W = CCU_TOL_W
`ifdef CCU_ACCIDENTALS_EN
   ,
   parameter int ACC_DLY = CCU_ACC_DLY
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pulse_a,
   input  logic             pulse_b,
   input  logic             start,
   input  logic             abort,
   input  logic [WIN_W-1:0] window_len,
   input  logic [TOL_W-1:0] tol,
   input  logic             ack,
   output logic             busy,
   output logic             valid,
   output logic [CNT_W-1:0] count_a,
   output logic [CNT_W-1:0] count_b,
   output logic [CNT_W-1:0] count_ab,
   output logic [1:0]       state_dbg
`ifdef CCU_ACCIDENTALS_EN
   ,
   output logic [CNT_W-1:0] count_acc
`endif
);

   ccu_state_e state;
   ccu_state_e state_nxt;

   logic [WIN_W-1:0] win_last;   // index of the last COUNT cycle
   logic [WIN_W-1:0] cyc;        // index of the current COUNT cycle
   logic [TOL_W-1:0] tol_q;

   logic latch_cfg;
   logic arm;
   logic counting;
   logic xfer;

   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;
   logic [CNT_W-1:0] cnt_ab;
   logic [CNT_W-1:0] cnt_a_nxt;
   logic [CNT_W-1:0] cnt_b_nxt;
   logic [CNT_W-1:0] cnt_ab_nxt;
   logic             ab_match;

   assign state_dbg = state;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      latch_cfg = 1'b0;
      arm       = 1'b0;
      counting  = 1'b0;
      xfer      = 1'b0;
      busy      = (state != ST_IDLE);
      valid     = (state == ST_DONE);
      case (state)
         ST_IDLE: begin
            // abort has priority over a simultaneous start
            if (start && !abort) begin
               latch_cfg = 1'b1;
               state_nxt = ST_ARM;
            end
         end
         ST_ARM: begin
            arm = 1'b1;
            if (abort) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else begin
               counting = 1'b1;
               if (cyc == win_last) begin
                  xfer      = 1'b1;
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (ack) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- window configuration and cycle counter ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_last <= '0;
         tol_q    <= '0;
         cyc      <= '0;
      end else begin
         if (latch_cfg) begin
            // A zero-length window still runs one COUNT cycle.
            win_last <= (window_len == '0) ? '0 : window_len - 1'b1;
            tol_q    <= tol;
         end
         if (arm) begin
            cyc <= '0;
         end else if (counting) begin
            cyc <= cyc + 1'b1;
         end
      end
   end

   // ---------------- coincidence matching ----------------
   coinc_match #(
      .TOL_W (TOL_W)
   ) u_match_ab (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (arm),
      .en      (counting),
      .pulse_x (pulse_a),
      .pulse_y (pulse_b),
      .tol     (tol_q),
      .match   (ab_match)
   );

   // ---------------- saturating internal counters ----------------
   always_comb begin
      cnt_a_nxt  = cnt_a;
      cnt_b_nxt  = cnt_b;
      cnt_ab_nxt = cnt_ab;
      if (counting && pulse_a && (cnt_a != '1)) begin
         cnt_a_nxt = cnt_a + 1'b1;
      end
      if (counting && pulse_b && (cnt_b != '1)) begin
         cnt_b_nxt = cnt_b + 1'b1;
      end
      if (ab_match && (cnt_ab != '1)) begin
         cnt_ab_nxt = cnt_ab + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || arm) begin
         cnt_a  <= '0;
         cnt_b  <= '0;
         cnt_ab <= '0;
      end else begin
         cnt_a  <= cnt_a_nxt;
         cnt_b  <= cnt_b_nxt;
         cnt_ab <= cnt_ab_nxt;
      end
   end

   // Outputs load the next-state counter values so the last COUNT cycle's
   // pulses are included in the transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_a  <= '0;
         count_b  <= '0;
         count_ab <= '0;
      end else if (xfer) begin
         count_a  <= cnt_a_nxt;
         count_b  <= cnt_b_nxt;
         count_ab <= cnt_ab_nxt;
      end
   end

`ifdef CCU_ACCIDENTALS_EN
   // ---------------- accidental coincidences ----------------
   logic [ACC_DLY-1:0] b_dly;
   logic               acc_match;
   logic [CNT_W-1:0]   cnt_acc;
   logic [CNT_W-1:0]   cnt_acc_nxt;

   // Free-running delay line; the oldest tap is pulse_b from ACC_DLY cycles ago.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         b_dly <= '0;
      end else begin
         b_dly <= (b_dly << 1) | ACC_DLY'(pulse_b);
      end
   end

   coinc_match #(
      .TOL_W (TOL_W)
   ) u_match_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (arm),
      .en      (counting),
      .pulse_x (pulse_a),
      .pulse_y (b_dly[ACC_DLY-1]),
      .tol     (tol_q),
      .match   (acc_match)
   );

   always_comb begin
      cnt_acc_nxt = cnt_acc;
      if (acc_match && (cnt_acc != '1)) begin
         cnt_acc_nxt = cnt_acc + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || arm) begin
         cnt_acc <= '0;
      end else begin
         cnt_acc <= cnt_acc_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_acc <= '0;
      end else if (xfer) begin
         count_acc <= cnt_acc_nxt;
      end
   end
`else
   // Accidental-coincidence path not built: no delay line, no count_acc.
`endif

endmodule

// File: tb/tb_count_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_count_window_ctrl
// Self-checking bench for count_window_ctrl (CNT_W=4 so saturation is
// reachable). Table of windows with expected counts, plus hand-written
// sequences for abort, DONE hold, IDLE corner cases and reset.
// Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_count_window_ctrl;

   localparam int CNT_W = 4;
   localparam int WIN_W = 32;
   localparam int TOL_W = 3;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst_n;
   logic             pulse_a;
   logic             pulse_b;
   logic             start;
   logic             abort;
   logic [WIN_W-1:0] window_len;
   logic [TOL_W-1:0] tol;
   logic             ack;
   logic             busy;
   logic             valid;
   logic [CNT_W-1:0] count_a;
   logic [CNT_W-1:0] count_b;
   logic [CNT_W-1:0] count_ab;
   logic [1:0]       state_dbg;

   always #5 clk = ~clk;

   count_window_ctrl #(
      .CNT_W (CNT_W),
      .WIN_W (WIN_W),
      .TOL_W (TOL_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pulse_a    (pulse_a),
      .pulse_b    (pulse_b),
      .start      (start),
      .abort      (abort),
      .window_len (window_len),
      .tol        (tol),
      .ack        (ack),
      .busy       (busy),
      .valid      (valid),
      .count_a    (count_a),
      .count_b    (count_b),
      .count_ab   (count_ab),
      .state_dbg  (state_dbg)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [3*CNT_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input int eb_busy, input int e_valid,
                                input int ea, input int eb, input int eab);
      check({tag, "_busy"},     busy,     eb_busy);
      check({tag, "_valid"},    valid,    e_valid);
      check({tag, "_count_a"},  count_a,  ea);
      check({tag, "_count_b"},  count_b,  eb);
      check({tag, "_count_ab"}, count_ab, eab);
   endtask

   // ---------------- driver tasks ----------------
   // Runs one window. Pulses are also driven during ARM and while waiting in
   // DONE; they must not be counted. With do_ack=0 the task returns in DONE.
   task automatic run_window(input int len, input int tl, input logic [63:0] am,
                             input logic [63:0] bm, input int ea, input int eb,
                             input int eab, input int hold, input bit do_ack);
      int n;
      int lat;
      logic [3*CNT_W-1:0] e;
      @(negedge clk);
      start      = 1'b1;
      window_len = WIN_W'(len);
      tol        = TOL_W'(tl);
      exp_q.push_back({CNT_W'(ea), CNT_W'(eb), CNT_W'(eab)});
      @(negedge clk);
      start = 1'b0;
      check("arm_state", state_dbg, 1);
      pulse_a = 1'b1;
      pulse_b = 1'b1;
      @(negedge clk);
      n = (len == 0) ? 1 : len;
      for (int i = 0; i < n; i++) begin
         if (i == 0) check("count_state", state_dbg, 2);
         if (i == n - 1) check("valid_low_in_count", valid, 0);
         pulse_a = am[i];
         pulse_b = bm[i];
         @(negedge clk);
      end
      pulse_a = 1'b0;
      pulse_b = 1'b0;
      lat = 0;
      while (!valid && lat < 4) begin
         @(negedge clk);
         lat++;
      end
      check("valid_latency", lat, 0);
      e = exp_q.pop_front();
      check("count_a",  count_a,  e[3*CNT_W-1 -: CNT_W]);
      check("count_b",  count_b,  e[2*CNT_W-1 -: CNT_W]);
      check("count_ab", count_ab, e[CNT_W-1:0]);
      for (int k = 0; k < hold; k++) begin
         pulse_a = 1'($urandom_range(0, 1));
         pulse_b = 1'($urandom_range(0, 1));
         start   = 1'($urandom_range(0, 1));
         abort   = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      pulse_a = 1'b0;
      pulse_b = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      if (hold > 0) begin
         check("done_hold_state", state_dbg, 3);
         check_outputs("done_hold", 1, 1, ea, eb, eab);
      end
      if (do_ack) begin
         ack = 1'b1;
         @(negedge clk);
         ack = 1'b0;
         check("after_ack_state", state_dbg, 0);
         check_outputs("after_ack", 0, 0, ea, eb, eab);
      end
   endtask

   // ---------------- stimulus table ----------------
   typedef struct {
      int         len;
      int         tl;
      logic [63:0] am;
      logic [63:0] bm;
      int         ea;
      int         eb;
      int         eab;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{10, 0, 64'h24,          64'h220, 2,  2, 1}; // basic, same-cycle pair at 5
      vecs[1] = '{8,  2, 64'h8,           64'h60,  1,  2, 1}; // tol 2: a@3 pairs b@5, b@6 unpaired
      vecs[2] = '{8,  2, 64'h8,           64'h40,  1,  1, 0}; // tol 2: b@6 is 3 cycles late
      vecs[3] = '{40, 0, 64'hFF_FFFF_FFFF, 64'h0,  15, 0, 0}; // singles saturate at 15
      vecs[4] = '{0,  0, 64'h1,           64'h1,   1,  1, 1}; // zero length runs one cycle
      vecs[5] = '{6,  1, 64'hC,           64'h2,   2,  1, 1}; // b pairs once, second a unpaired
      vecs[6] = '{12, 7, 64'h1,           64'h180, 1,  2, 1}; // max tolerance, age exactly 7
      vecs[7] = '{5,  3, 64'h1F,          64'h10,  5,  1, 1}; // simultaneous pair wins, one count
      vecs[8] = '{4,  0, 64'h8,           64'h8,   1,  1, 1}; // pulses on the last COUNT cycle

      rst_n      = 1'b0;
      pulse_a    = 1'b0;
      pulse_b    = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      window_len = '0;
      tol        = '0;
      ack        = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", state_dbg, 0);
      check_outputs("reset", 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      // Table-driven windows; the first one also holds DONE for 20 cycles
      // with start/abort poked.
      for (int v = 0; v < 9; v++) begin
         run_window(vecs[v].len, vecs[v].tl, vecs[v].am, vecs[v].bm,
                    vecs[v].ea, vecs[v].eb, vecs[v].eab, (v == 0) ? 20 : 2, 1'b1);
      end
      // Outputs now hold 1/1/1 from the last vector.

      // ack and start+abort in IDLE: no effect.
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack   = 1'b0;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("idle_start_abort_state", state_dbg, 0);
      check_outputs("idle_noop", 0, 0, 1, 1, 1);

      // Abort during ARM.
      start      = 1'b1;
      window_len = 32'd10;
      tol        = 3'd0;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_arm_state", state_dbg, 0);
      check_outputs("abort_arm", 0, 0, 1, 1, 1);

      // Abort at COUNT cycle 4 of 10 after counting pulses.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         pulse_a = 1'b1;
         pulse_b = 1'b1;
         if (i == 3) abort = 1'b1;
         @(negedge clk);
      end
      pulse_a = 1'b0;
      pulse_b = 1'b0;
      abort   = 1'b0;
      check("abort_count_state", state_dbg, 0);
      check_outputs("abort_count", 0, 0, 1, 1, 1);
      repeat (12) @(negedge clk);
      check_outputs("abort_count_later", 0, 0, 1, 1, 1);

      // Reset mid-COUNT discards the window and clears the outputs.
      start      = 1'b1;
      window_len = 32'd10;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      pulse_a = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n   = 1'b1;
      pulse_a = 1'b0;
      check("rst_count_state", state_dbg, 0);
      check_outputs("rst_count", 0, 0, 0, 0, 0);

      // Reset mid-DONE discards the unacknowledged result.
      run_window(6, 1, 64'h7, 64'h20, 3, 1, 0, 3, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_done_state", state_dbg, 0);
      check_outputs("rst_done", 0, 0, 0, 0, 0);

      // A fresh window still works after reset.
      run_window(3, 0, 64'h5, 64'h4, 2, 1, 1, 1, 1'b1);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time bound so the bench always ends.
   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/count_window_ctrl.md
COUNT_WINDOW_CTRL -- requirements
Module: count_window_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of every count output.
REQ-002 Parameter WIN_W, default 32: width of window_len.
REQ-003 Parameter TOL_W, default 3: width of the coincidence tolerance input.
REQ-004 clk  in  1  sole clock; all logic on posedge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 pulse_a / pulse_b  in  1 each  single-cycle conditioned detector pulses, one per detector channel.
REQ-007 start  in  1  request to open a counting window.
REQ-008 abort  in  1  cancel the running window.
REQ-009 window_len  in  WIN_W  window length in clk cycles.
REQ-010 tol  in  TOL_W  coincidence tolerance in cycles.
REQ-011 ack  in  1  consumer has taken the results.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 valid  out  1  results on the count outputs are stable and unread.
REQ-014 count_a / count_b / count_ab  out  CNT_W each  singles A, singles B and AB coincidences for the last completed window.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, ARM, COUNT and DONE.
REQ-016 In IDLE, start=1 with abort=0 SHALL latch window_len and tol and move to ARM; start is ignored in all other states.
REQ-017 ARM SHALL last exactly one cycle: clear internal counters and pulse-age trackers, then go to COUNT.
REQ-018 COUNT SHALL last exactly max(window_len,1) cycles; pulses are counted only in COUNT cycles.
REQ-019 Each COUNT cycle with pulse_a=1 SHALL increment internal A by 1; likewise for B.
REQ-020 An AB coincidence SHALL be counted when a pulse arrives on one channel and the other channel has an unpaired pulse aged 0..tol cycles (age 0 = same cycle).
REQ-021 Each pulse SHALL take part in at most one coincidence; both pulses are marked paired when the coincidence is counted.
REQ-022 pulse_a and pulse_b in the same cycle SHALL count exactly one coincidence.
REQ-023 All internal counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 On the last COUNT cycle, that cycle's pulses SHALL be included; the next cycle copies the internal counters to the outputs, sets valid=1 and enters DONE.
REQ-025 Output counts SHALL change only on that transfer and SHALL hold their value otherwise.
REQ-026 In DONE, valid SHALL stay 1 until ack=1 is sampled; the next cycle valid=0 and the state is IDLE.
REQ-027 ack outside DONE SHALL have no effect.
REQ-028 abort=1 in ARM or COUNT SHALL return to IDLE on the next cycle with no output update and valid=0.
REQ-029 abort in DONE SHALL be ignored; ack alone ends DONE.
REQ-030 abort and start together in IDLE: abort wins and the state stays IDLE.

Reset
REQ-031 rst_n=0 at any posedge SHALL force IDLE, clear all outputs, counters and trackers, and discard any window in progress or unacknowledged result.

Configuration
REQ-032 CCU_ACCIDENTALS_EN defined: add output count_acc (CNT_W). It counts coincidences of pulse_a against pulse_b delayed by parameter ACC_DLY (default 16) cycles, with the same tol, pairing and saturation rules; it is transferred with the other counts.
REQ-033 CCU_ACCIDENTALS_EN undefined: no count_acc port and no delay line.

Structure
REQ-034 Package ccu_pkg SHALL hold the FSM state enum, default CNT_W/WIN_W/TOL_W and ACC_DLY.
REQ-035 Sub-module coinc_match SHALL implement the tolerance/pairing logic of REQ-020..022.
REQ-036 coinc_match is instantiated once for AB and, when enabled, once more for accidentals.

Verification
REQ-037 window_len=10, tol=0, pulse_a at COUNT cycles 2,5 and pulse_b at 5,9 -> count_a=2, count_b=2, count_ab=1, valid 1 cycle after the last COUNT cycle.
REQ-038 tol=2, pulse_a at cycle 3, pulse_b at 5 then 6 -> count_ab=1; pulse_b at 6 alone -> count_ab=0.
REQ-039 CNT_W=4, pulse_a every cycle, window_len=40 -> count_a=15 (saturated).
REQ-040 abort at COUNT cycle 4 of 10 -> IDLE next cycle, valid stays 0, outputs keep previous values.
REQ-041 valid held with ack=0 for 20 cycles, start pulsed -> no new window; ack=1 -> valid=0, IDLE next cycle.
REQ-042 rst_n=0 mid-COUNT and mid-DONE -> all outputs 0, busy=0 the next cycle.
